mux_16: RTL and testbench
=========================

Name: mux_16

Overview:
- 16-bit two-way word selector for the Hack-style datapath built up from NAND-derived primitives.
- Combinational path: out follows a when sel=0 and b when sel=1, with no clock dependency.
- Also provides a registered copy of the selected word, out_q, so downstream sequential logic can take a timing-clean version.
- Sits between register/ALU sources and the next datapath stage (A/M operand select, PC load select).

Parameters:
- WIDTH, 16, data word width in bits. Only 16 is required to be supported and tested.

Ports:
- clk  input  1  rising-edge clock for the out_q register only.
- rst_n  input  1  asynchronous active-low reset; clears out_q.
- a  input  WIDTH  word selected when sel=0.
- b  input  WIDTH  word selected when sel=1.
- sel  input  1  select; 0 picks a, 1 picks b.
- out  output  WIDTH  combinational selected word.
- out_q  output  WIDTH  registered selected word.
- Declaration order is fixed: a, b, sel, out, clk, rst_n, out_q. The first four are connected positionally in existing benches.

Behaviour:
- Combinational path:
  - out[i] = (a[i] AND NOT sel) OR (b[i] AND sel), for every bit i.
  - Built per bit from the codebase's not/and/or gates (NAND-derived); no behavioural ternary at the top level.
  - Zero clock latency: out settles within the same time step after any change on a, b or sel.
  - out does not depend on clk or rst_n. It is valid even when clk and rst_n are unconnected or X.
  - out must be X-free whenever a, b and sel are known.
  - Bits are independent: no cross-bit logic, no bit reordering, no sign or zero extension.
- Registered path:
  - On the rising edge of clk with rst_n=1, out_q <= the value out has just before that edge.
  - rst_n=0 forces out_q to 0x0000 immediately, without waiting for a clock edge, and holds it there while low.
  - Reset deasserted between edges: out_q stays 0x0000 until the first rising edge, then loads the current selection.
  - Latency of out_q relative to out is 1 cycle.
  - A sel change coincident with a clock edge: out_q captures the pre-edge selection.
  - Reset asserted mid-operation clears out_q only; the combinational out is unaffected.
- No internal state other than the out_q register.
- No enable, no handshake; every cycle loads.

Test Plan:
- a=0x0000, b=0x1234, sel=0; wait 10 time units -> out=0x0000 (b is ignored).
- a=0xAAAA, b=0x5555, sel=0; wait 10 -> out=0xAAAA.
- a=0xAAAA, b=0x5555, sel=1; wait 10 -> out=0x5555. Then toggle sel to 0 -> out returns to 0xAAAA with no clock edge applied.
- Walking-one checks:
  - a=1<<i, b=0, sel=0 -> out=1<<i, for i=0..15.
  - Repeat with a=0, b=1<<i, sel=1 -> out=1<<i.
- Registered path:
  - rst_n=0 -> out_q=0x0000 with no clock edge.
  - Release rst_n with a=0xAAAA, b=0x5555, sel=1 -> out_q stays 0x0000 until the first rising edge, then becomes 0x5555.
  - Set sel=0 -> out_q becomes 0xAAAA one edge later.
- Mid-operation reset: with out_q=0xFFFF (a=0xFFFF, sel=0), pulse rst_n=0 between edges -> out_q=0x0000 at once while out stays 0xFFFF.

Source files
------------

// File: rtl/mux_16.sv
// Two-way word selector built bit-by-bit from NAND-derived gates,
// with a registered copy of the selected word for downstream timing.
module mux_16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] out_q
);

    function automatic logic nand_g(input logic x, input logic y);
        return ~(x & y);
    endfunction

    function automatic logic not_g(input logic x);
        return nand_g(x, x);
    endfunction

    function automatic logic and_g(input logic x, input logic y);
        return not_g(nand_g(x, y));
    endfunction

    function automatic logic or_g(input logic x, input logic y);
        return nand_g(not_g(x), not_g(y));
    endfunction

    logic             sel_n;
    logic [WIDTH-1:0] out_d;

    assign sel_n = not_g(sel);

    // Each bit is an independent AND-OR select; no logic crosses bit lanes.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign out[i] = or_g(and_g(a[i], sel_n), and_g(b[i], sel));
    end

    always_comb begin
        out_d = out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_mux_16.sv
// Self-checking bench for mux_16: directed checks of the combinational and
// registered paths, then randomized words against a simple selection model.
module tb_mux_16;

    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic [15:0] out;
    logic        clk;
    logic        rst_n;
    logic [15:0] out_q;

    int vectors;
    int miscompares;
    logic [15:0] model_q;

    mux_16 #(.WIDTH(16)) dut (
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .clk   (clk),
        .rst_n (rst_n),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the word indexed by sel out of the pair {a, b}.
    function automatic logic [15:0] ref_select(input logic [15:0] wa,
                                               input logic [15:0] wb,
                                               input logic        s);
        logic [15:0] words [2];
        words[0] = wa;
        words[1] = wb;
        return words[int'(s)];
    endfunction

    task automatic applyStimulus(input logic [15:0] na, input logic [15:0] nb,
                                 input logic ns);
        a   = na;
        b   = nb;
        sel = ns;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_q     = '0;
        rst_n       = 1'b0;
        applyStimulus(16'h0000, 16'h1234, 1'b0);

        // Reset holds out_q at zero before any clock edge arrives.
        #1;
        checkOutput("reset_out_q", out_q, 16'h0000);
        checkOutput("sel0_b_ignored", out, 16'h0000);

        #10;
        checkOutput("sel0_b_ignored_late", out, 16'h0000);
        applyStimulus(16'hAAAA, 16'h5555, 1'b0);
        #10;
        checkOutput("sel0_aaaa", out, 16'hAAAA);
        applyStimulus(16'hAAAA, 16'h5555, 1'b1);
        #10;
        checkOutput("sel1_5555", out, 16'h5555);
        sel = 1'b0;
        #1;
        checkOutput("sel_toggle_back", out, 16'hAAAA);
        checkOutput("reset_hold_out_q", out_q, 16'h0000);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(16'h0001 << i, 16'h0000, 1'b0);
            #1;
            checkOutput($sformatf("walk_a_%0d", i), out, 16'h0001 << i);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(16'h0000, 16'h0001 << i, 1'b1);
            #1;
            checkOutput($sformatf("walk_b_%0d", i), out, 16'h0001 << i);
        end

        // Release reset between edges; out_q must wait for the next rising edge.
        @(negedge clk);
        applyStimulus(16'hAAAA, 16'h5555, 1'b1);
        rst_n = 1'b1;
        #2;
        checkOutput("release_hold", out_q, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("first_edge_load", out_q, 16'h5555);
        @(negedge clk);
        sel = 1'b0;
        #1;
        checkOutput("pre_edge_keep", out_q, 16'h5555);
        @(posedge clk);
        #1;
        checkOutput("sel0_edge_load", out_q, 16'hAAAA);

        // Asynchronous reset pulse mid-operation clears only out_q.
        @(negedge clk);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("ffff_loaded", out_q, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_q", out_q, 16'h0000);
        checkOutput("midop_reset_out", out, 16'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midop_release_hold", out_q, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("midop_reload", out_q, 16'hFFFF);

        // Randomized words and selects, one new vector per cycle.
        model_q = 16'hFFFF;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            applyStimulus(16'($urandom()), 16'($urandom()), 1'($urandom()));
            #1;
            checkOutput("rand_out", out, ref_select(a, b, sel));
            checkOutput("rand_q_hold", out_q, model_q);
            @(posedge clk);
            model_q = ref_select(a, b, sel);
            #1;
            checkOutput("rand_out_q", out_q, model_q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
